// File: rtl/ov9281_sccb_slave.sv
`timescale 1ns/1ps
// SCCB/I2C responder standing in for the OV9281 register target: 7-bit device
// address, 16-bit auto-incrementing register address, 8-bit data, stream bit tracking.
module ov9281_sccb_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h60,
    parameter int          FILTER_LEN = 3
) (
    input  logic        clk_24M,
    input  logic        camera_rstn,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        reg_wr_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata,
    output logic        stream_on,
    output logic [15:0] wr_count,
    output logic        busy
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DEV    = 3'd1;
    localparam logic [2:0] S_AHI    = 3'd2;
    localparam logic [2:0] S_ALO    = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;
    localparam logic [2:0] S_RD     = 3'd5;
    localparam logic [2:0] S_RACK   = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    logic [1:0]    r_scl_s, r_sda_s;
    logic          r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    logic [CW-1:0] r_scl_cnt, r_sda_cnt;
    logic [2:0]    r_state, r_next;
    logic [3:0]    r_bit_cnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_tx;
    logic          r_ack_ph, r_do_ack, r_load, r_sda_oe;
    logic          r_wr_en, r_stream, r_busy;
    logic [15:0]   r_addr, r_wr_count;
    logic [7:0]    r_wdata;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_byte     = {r_shift, r_sda_f};

    assign i2c_sdat  = r_sda_oe ? 1'b0 : 1'bz;
    assign reg_wr_en = r_wr_en;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign stream_on = r_stream;
    assign wr_count  = r_wr_count;
    assign busy      = r_busy;

    // Synchronize and glitch-filter SCL/SDA; filters reset high so reset never fakes an edge.
    always_ff @(posedge clk_24M) begin
        if (!camera_rstn) begin
            r_scl_s   <= 2'b11;
            r_sda_s   <= 2'b11;
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
        end else begin
            r_scl_s <= {r_scl_s[0], i2c_sclk};
            r_sda_s <= {r_sda_s[0], i2c_sdat};
            r_scl_d <= r_scl_f;
            r_sda_d <= r_sda_f;
            if (r_scl_s[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FILT_MAX) begin
                r_scl_f   <= r_scl_s[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
            if (r_sda_s[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FILT_MAX) begin
                r_sda_f   <= r_sda_s[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    // Protocol FSM: STOP/START override everything, then per-state byte handling.
    always_ff @(posedge clk_24M) begin
        if (!camera_rstn) begin
            r_state    <= S_IDLE;
            r_next     <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 7'd0;
            r_tx       <= 8'd0;
            r_ack_ph   <= 1'b0;
            r_do_ack   <= 1'b0;
            r_load     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_stream   <= 1'b0;
            r_busy     <= 1'b0;
            r_addr     <= 16'd0;
            r_wr_count <= 16'd0;
            r_wdata    <= 8'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_load  <= 1'b0;
            // Read data is captured the cycle after the address register updates.
            if (r_load) begin
                r_tx <= reg_rdata;
            end
            if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_ack_ph  <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else if (w_start) begin
                r_state   <= S_DEV;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
                r_ack_ph  <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    S_DEV, S_AHI, S_ALO, S_WR: begin
                        if (w_scl_rise && !r_ack_ph && r_bit_cnt != 4'd8) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                case (r_state)
                                    S_DEV: begin
                                        r_do_ack <= (w_byte[7:1] == DEV_ADDR);
                                        r_load   <= w_byte[0];
                                        if (w_byte[7:1] != DEV_ADDR) begin
                                            r_next <= S_IGNORE;
                                        end else if (w_byte[0]) begin
                                            r_next <= S_RD;
                                        end else begin
                                            r_next <= S_AHI;
                                        end
                                    end
                                    S_AHI: begin
                                        r_addr[15:8] <= w_byte;
                                        r_do_ack     <= 1'b1;
                                        r_next       <= S_ALO;
                                    end
                                    S_ALO: begin
                                        r_addr[7:0] <= w_byte;
                                        r_do_ack    <= 1'b1;
                                        r_next      <= S_WR;
                                    end
                                    default: begin
                                        r_wdata    <= w_byte;
                                        r_wr_en    <= 1'b1;
                                        r_wr_count <= r_wr_count + 16'd1;
                                        if (r_addr == 16'h0100) begin
                                            r_stream <= w_byte[0];
                                        end
                                        r_do_ack <= 1'b1;
                                        r_next   <= S_WR;
                                    end
                                endcase
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            if (!r_ack_ph) begin
                                r_ack_ph <= 1'b1;
                                r_sda_oe <= r_do_ack;
                            end else begin
                                r_ack_ph  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= r_next;
                                r_sda_oe  <= (r_next == S_RD) ? ~r_tx[7] : 1'b0;
                                if (r_state == S_WR) begin
                                    r_addr <= r_addr + 16'd1;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RACK;
                            end else begin
                                r_sda_oe <= ~r_tx[3'd7 - r_bit_cnt[2:0]];
                            end
                        end
                    end
                    S_RACK: begin
                        if (w_scl_rise && !r_ack_ph) begin
                            if (!r_sda_f) begin
                                r_ack_ph <= 1'b1;
                                r_addr   <= r_addr + 16'd1;
                                r_load   <= 1'b1;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_ack_ph  <= 1'b0;
                            r_sda_oe  <= ~r_tx[7];
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_RD;
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov9281_sccb_slave.sv
`timescale 1ns/1ps
// Directed bench: bit-banged SCCB master against ov9281_sccb_slave with a
// two-entry register read model and a write-strobe recorder.
module tb_ov9281_sccb_slave;

    localparam int Q = 12;

    logic        clk_24M = 1'b0;
    logic        camera_rstn = 1'b0;
    logic        i2c_sclk = 1'b1;
    logic        m_low = 1'b0;
    wire         i2c_sdat;
    logic        reg_wr_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        stream_on;
    logic [15:0] wr_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] strobes[$];

    pullup (i2c_sdat);
    assign i2c_sdat = m_low ? 1'b0 : 1'bz;

    assign reg_rdata = (reg_addr == 16'h300A) ? 8'h92 :
                       (reg_addr == 16'h300B) ? 8'h81 : 8'h00;

    ov9281_sccb_slave dut (
        .clk_24M     (clk_24M),
        .camera_rstn (camera_rstn),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat    (i2c_sdat),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .stream_on   (stream_on),
        .wr_count    (wr_count),
        .busy        (busy)
    );

    always #20 clk_24M = ~clk_24M;

    always @(posedge clk_24M) begin
        if (reg_wr_en === 1'b1) strobes.push_back({reg_addr, reg_wdata});
    end

    initial begin
        #10_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_24M);
    endtask

    task automatic do_start();
        m_low = 1'b0; wait_clk(Q);
        i2c_sclk = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        i2c_sclk = 1'b0; wait_clk(Q);
    endtask

    task automatic do_stop();
        m_low = 1'b1; wait_clk(Q);
        i2c_sclk = 1'b1; wait_clk(Q);
        m_low = 1'b0; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_low = ~b[7-i]; wait_clk(Q);
            i2c_sclk = 1'b1; wait_clk(2*Q);
            i2c_sclk = 1'b0; wait_clk(Q);
        end
        m_low = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        wait_clk(Q);
        i2c_sclk = 1'b1; wait_clk(Q);
        ack = (i2c_sdat === 1'b0);
        wait_clk(Q);
        i2c_sclk = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input logic do_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; wait_clk(Q);
            i2c_sclk = 1'b1; wait_clk(Q);
            b[i] = (i2c_sdat !== 1'b0);
            wait_clk(Q);
            i2c_sclk = 1'b0; wait_clk(Q);
        end
        m_low = do_ack; wait_clk(Q);
        i2c_sclk = 1'b1; wait_clk(2*Q);
        i2c_sclk = 1'b0; wait_clk(Q);
        m_low = 1'b0;
    endtask

    task automatic pulse_reset();
        camera_rstn = 1'b0; wait_clk(4);
        camera_rstn = 1'b1; wait_clk(10);
    endtask

    task automatic test_reset();
        i2c_sclk = 1'b1; m_low = 1'b0;
        pulse_reset();
        checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", reg_wr_en); end
        checks++; if (reg_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", reg_wdata); end
        checks++; if (stream_on !== 1'b0) begin errors++; $display("FAIL reset_stream got %b exp 0", stream_on); end
        checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL reset_wr_count got %h exp 0000", wr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (i2c_sdat !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", i2c_sdat); end
    endtask

    task automatic test_single_write();
        logic [3:0] acks;
        strobes.delete();
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_start got %b exp 1", busy); end
        write_byte(8'hC0, acks[3]);
        write_byte(8'h01, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h01, acks[0]);
        do_stop();
        checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL sw_acks got %b exp 1111", acks); end
        checks++; if (strobes.size() != 1) begin errors++; $display("FAIL sw_strobe_count got %0d exp 1", strobes.size()); end
        checks++; if (strobes[0] !== 24'h010001) begin errors++; $display("FAIL sw_strobe got %h exp 010001", strobes[0]); end
        checks++; if (stream_on !== 1'b1) begin errors++; $display("FAIL sw_stream got %b exp 1", stream_on); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL sw_wr_count got %0d exp 1", wr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_stop got %b exp 0", busy); end
    endtask

    task automatic test_wrong_device();
        logic [2:0] acks;
        strobes.delete();
        do_start();
        write_byte(8'hC2, acks[2]);
        write_byte(8'h30, acks[1]);
        write_byte(8'h01, acks[0]);
        do_stop();
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL wd_acks got %b exp 000", acks); end
        checks++; if (strobes.size() != 0) begin errors++; $display("FAIL wd_strobe_count got %0d exp 0", strobes.size()); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wd_wr_count got %0d exp 1", wr_count); end
    endtask

    task automatic test_burst();
        logic [5:0] acks;
        pulse_reset();
        strobes.delete();
        do_start();
        write_byte(8'hC0, acks[5]);
        write_byte(8'h38, acks[4]);
        write_byte(8'h08, acks[3]);
        write_byte(8'h05, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h03, acks[0]);
        do_stop();
        checks++; if (acks !== 6'h3F) begin errors++; $display("FAIL bu_acks got %b exp 111111", acks); end
        checks++; if (strobes.size() != 3) begin errors++; $display("FAIL bu_strobe_count got %0d exp 3", strobes.size()); end
        checks++; if (strobes[0] !== 24'h380805) begin errors++; $display("FAIL bu_strobe0 got %h exp 380805", strobes[0]); end
        checks++; if (strobes[1] !== 24'h380900) begin errors++; $display("FAIL bu_strobe1 got %h exp 380900", strobes[1]); end
        checks++; if (strobes[2] !== 24'h380A03) begin errors++; $display("FAIL bu_strobe2 got %h exp 380A03", strobes[2]); end
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL bu_wr_count got %0d exp 3", wr_count); end
        checks++; if (stream_on !== 1'b0) begin errors++; $display("FAIL bu_stream got %b exp 0", stream_on); end
    endtask

    task automatic test_read();
        logic [3:0] acks;
        logic [7:0] b0, b1;
        strobes.delete();
        do_start();
        write_byte(8'hC0, acks[3]);
        write_byte(8'h30, acks[2]);
        write_byte(8'h0A, acks[1]);
        do_start();
        write_byte(8'hC1, acks[0]);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        wait_clk(Q);
        checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL rd_acks got %b exp 1111", acks); end
        checks++; if (b0 !== 8'h92) begin errors++; $display("FAIL rd_byte0 got %h exp 92", b0); end
        checks++; if (b1 !== 8'h81) begin errors++; $display("FAIL rd_byte1 got %h exp 81", b1); end
        checks++; if (i2c_sdat !== 1'b1) begin errors++; $display("FAIL rd_sda_released got %b exp 1", i2c_sdat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_before_stop got %b exp 1", busy); end
        checks++; if (reg_addr !== 16'h300B) begin errors++; $display("FAIL rd_addr got %h exp 300B", reg_addr); end
        do_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %b exp 0", busy); end
        checks++; if (strobes.size() != 0) begin errors++; $display("FAIL rd_strobe_count got %0d exp 0", strobes.size()); end
    endtask

    task automatic test_abort();
        logic [3:0] acks;
        strobes.delete();
        do_start();
        write_byte(8'hC0, acks[3]);
        write_byte(8'h12, acks[2]);
        write_byte(8'h34, acks[1]);
        send_bits(8'hFF, 5);
        do_stop();
        checks++; if (strobes.size() != 0) begin errors++; $display("FAIL ab_partial_strobe got %0d exp 0", strobes.size()); end
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL ab_wr_count got %0d exp 3", wr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b exp 0", busy); end
        do_start();
        write_byte(8'hC0, acks[3]);
        write_byte(8'h01, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h01, acks[0]);
        checks++; if (stream_on !== 1'b1) begin errors++; $display("FAIL ab_stream_set got %b exp 1", stream_on); end
        do_start();
        send_bits(8'hC0, 8);
        checks++; if (i2c_sdat !== 1'b0) begin errors++; $display("FAIL ab_ack_driven got %b exp 0", i2c_sdat); end
        camera_rstn = 1'b0;
        wait_clk(1);
        checks++; if (i2c_sdat !== 1'b1) begin errors++; $display("FAIL ab_rst_sda got %b exp 1", i2c_sdat); end
        checks++; if (stream_on !== 1'b0) begin errors++; $display("FAIL ab_rst_stream got %b exp 0", stream_on); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL ab_rst_wr_count got %0d exp 0", wr_count); end
        camera_rstn = 1'b1;
        wait_clk(Q);
        do_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_glitch_wrap();
        logic [4:0] acks;
        logic       seen_busy;
        strobes.delete();
        seen_busy = 1'b0;
        i2c_sclk = 1'b0; wait_clk(1);
        i2c_sclk = 1'b1; wait_clk(10);
        m_low = 1'b1; wait_clk(1);
        m_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            wait_clk(1);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL gl_busy_seen got %b exp 0", seen_busy); end
        checks++; if (i2c_sdat !== 1'b1) begin errors++; $display("FAIL gl_sda got %b exp 1", i2c_sdat); end
        do_start();
        write_byte(8'hC0, acks[4]);
        write_byte(8'hFF, acks[3]);
        write_byte(8'hFF, acks[2]);
        write_byte(8'hAA, acks[1]);
        write_byte(8'hBB, acks[0]);
        do_stop();
        checks++; if (acks !== 5'h1F) begin errors++; $display("FAIL wr_acks got %b exp 11111", acks); end
        checks++; if (strobes.size() != 2) begin errors++; $display("FAIL wr_strobe_count got %0d exp 2", strobes.size()); end
        checks++; if (strobes[0] !== 24'hFFFFAA) begin errors++; $display("FAIL wr_strobe0 got %h exp FFFFAA", strobes[0]); end
        checks++; if (strobes[1] !== 24'h0000BB) begin errors++; $display("FAIL wr_strobe1 got %h exp 0000BB", strobes[1]); end
        checks++; if (reg_addr !== 16'h0001) begin errors++; $display("FAIL wr_addr got %h exp 0001", reg_addr); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL wr_wr_count got %0d exp 2", wr_count); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrong_device();
        test_burst();
        test_read();
        test_abort();
        test_glitch_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov9281_sccb_slave.md
Name: ov9281_sccb_slave

Overview:
- Synthesizable I2C/SCCB responder that models the OV9281 register target: 7-bit device address, 16-bit register address, 8-bit data.
- Serves as the far end of the camera configuration bus. Used in system simulation in place of the sensor, and as an on-FPGA loopback target for bring-up of the configuration master.
- Decodes write and read transactions and presents them on a simple register-file port.
- Tracks the streaming bit (register 0x0100, bit 0) so downstream video models can gate frame generation.

Parameters:
- DEV_ADDR, 7'h60, 7-bit device address (8-bit write byte 0xC0, read byte 0xC1).
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes.

Ports:
- clk_24M  input  1  system clock; oversamples the bus.
- camera_rstn  input  1  synchronous active-low reset.
- i2c_sclk  input  1  bus clock from the master.
- i2c_sdat  inout  1  bus data; driven only as 0 or Z.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_addr  output  16  register address for write or read.
- reg_wdata  output  8  write data, valid with reg_wr_en.
- reg_rdata  input  8  read data; sampled 1 cycle after reg_addr settles.
- stream_on  output  1  mirror of register 0x0100 bit 0.
- wr_count  output  16  number of completed data-byte writes; wraps at 0xFFFF.
- busy  output  1  high from START to STOP.

Behaviour:

Reset (while camera_rstn=0 at a clk_24M edge):
- All outputs 0; reg_addr=0; SDA released (Z); FSM in IDLE.
- Reset mid-transaction aborts at once; the slave stays idle until the next START.

Input conditioning and edge detection:
- SCL and SDA pass through a 2-flop synchronizer, then a FILTER_LEN glitch filter. All edges below refer to the filtered signals.
- START: SDA falls while SCL=1.
- STOP: SDA rises while SCL=1.
- Repeated START is a START while busy.
- Data bits are sampled on the SCL rising edge, MSB first.
- SDA output changes only on the clk_24M cycle after the SCL falling edge is detected.

ACK timing:
- Slave pulls SDA low from the falling edge after bit 8 until the falling edge after the 9th clock.

FSM states:
- IDLE: wait for START → DEV.
- DEV: shift 8 bits.
  - addr==DEV_ADDR: ACK, then go to RD if R/W=1 (and a register address has been latched), else to AHI.
  - Mismatch: no ACK → IGNORE.
- AHI: shift 8 bits → reg_addr[15:8]; ACK → ALO.
- ALO: shift 8 bits → reg_addr[7:0]; ACK → WR.
- WR: shift 8 bits.
  - On the 8th rising edge: reg_wdata=byte; reg_wr_en pulses for 1 cycle; wr_count+1.
  - If reg_addr==0x0100, stream_on<=byte[0].
  - ACK; then reg_addr+1 (16-bit wrap 0xFFFF→0x0000); stay in WR for a burst.
- RD: drive bit 7 of the latched reg_rdata after the ACK falling edge; shift out on each SCL fall → RACK.
- RACK: sample master ACK on the 9th rising edge.
  - ACK=0: reg_addr+1, reload reg_rdata, → RD.
  - NACK: release SDA → IGNORE.
- IGNORE: SDA released; wait for STOP or START.

Global rules:
- STOP in any state: release SDA, → IDLE, busy=0.
- START in any state (including mid-byte): discard the partial byte → DEV.
- A partial byte at STOP produces no write strobe.
- A reg_addr set in AHI/ALO is retained across STOP so that write-address + repeated START + read works.
- SDA is never driven high. If the master's START and the slave's ACK release collide, START takes priority.

Test Plan:
1. Single write: bytes 0xC0, 0x01, 0x00, 0x01, STOP → 4 ACKs; one reg_wr_en with reg_addr=0x0100, reg_wdata=0x01; stream_on=1; wr_count=1.
2. Wrong device: bytes 0xC2, 0x30, 0x01 → no ACK on any byte; reg_wr_en never asserts; wr_count unchanged.
3. Burst write: 0xC0, 0x38, 0x08, then data 0x05, 0x00, 0x03 → three strobes at addresses 0x3808/0x3809/0x380A with the matching data; wr_count=3.
4. Read: write address 0x300A, repeated START, 0xC1; reg_rdata model returns 0x92 then 0x81; master ACKs then NACKs → bytes shifted out are 0x92, 0x81; SDA released after the NACK; busy falls at STOP.
5. Abort: STOP after 5 bits of a data byte → no strobe. Then camera_rstn low during an ACK → SDA released next cycle and stream_on=0.
6. Glitch: 1-cycle SCL pulse of 1 clk_24M during the idle bus → no START/bit detected and state remains IDLE. Also 0xFFFF auto-increment wraps to 0x0000.
